// File: rtl/uart_cmd_ctrl.sv
// UART command controller: parses write/read/ping frames from the RX byte stream,
// drives register-file strobes and returns read data over the TX busy handshake.
module uart_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_p_data,
  input  logic                  rx_d_valid,
  input  logic                  rx_err,
  input  logic                  tx_busy,
  output logic [DATA_WIDTH-1:0] tx_p_data,
  output logic                  tx_d_valid,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic                  rf_wr_en,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  rf_rd_en,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  input  logic                  rf_rd_valid,
  output logic                  cmd_err,
  output logic                  ctrl_busy
);
  localparam int CW = $clog2(RD_TIMEOUT) + 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_ADDR = 3'd1;
  localparam logic [2:0] WR_DATA = 3'd2;
  localparam logic [2:0] RD_ADDR = 3'd3;
  localparam logic [2:0] RD_WAIT = 3'd4;
  localparam logic [2:0] TX_REQ  = 3'd5;
  localparam logic [2:0] TX_HOLD = 3'd6;

  localparam logic [DATA_WIDTH-1:0] OP_WR   = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD   = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_PING = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] PONG    = DATA_WIDTH'(8'h5A);
  localparam logic [CW-1:0]         TO_LAST = CW'(RD_TIMEOUT - 1);

  logic [2:0]            state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wdata_n, txd_n;
  logic                  txv_n, wr_n, rd_n, err_n, parsing;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = rf_addr;
    wdata_n = rf_wr_data;
    txd_n   = tx_p_data;
    txv_n   = tx_d_valid;
    wr_n    = 1'b0;
    rd_n    = 1'b0;
    err_n   = 1'b0;
    parsing = (state == IDLE) || (state == WR_ADDR) || (state == WR_DATA) || (state == RD_ADDR);

    // Bytes while a response is outstanding are dropped but still flagged.
    if (rx_d_valid && !parsing) err_n = 1'b1;

    if (parsing && rx_d_valid && rx_err) begin
      err_n   = 1'b1;
      state_n = IDLE;
    end else if (parsing && rx_d_valid) begin
      case (state)
        IDLE: begin
          if (rx_p_data == OP_WR)        state_n = WR_ADDR;
          else if (rx_p_data == OP_RD)   state_n = RD_ADDR;
          else if (rx_p_data == OP_PING) begin
            txd_n   = PONG;
            state_n = TX_REQ;
          end else err_n = 1'b1;
        end
        WR_ADDR: begin
          addr_n  = rx_p_data[ADDR_WIDTH-1:0];
          state_n = WR_DATA;
        end
        WR_DATA: begin
          wdata_n = rx_p_data;
          wr_n    = 1'b1;
          state_n = IDLE;
        end
        default: begin
          addr_n  = rx_p_data[ADDR_WIDTH-1:0];
          rd_n    = 1'b1;
          cnt_n   = '0;
          state_n = RD_WAIT;
        end
      endcase
    end

    case (state)
      RD_WAIT: begin
        // Data beats a timeout landing on the same cycle.
        if (rf_rd_valid) begin
          txd_n   = rf_rd_data;
          state_n = TX_REQ;
        end else if (cnt == TO_LAST) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else if (cnt != {CW{1'b1}}) begin
          cnt_n = cnt + 1'b1;
        end
      end
      TX_REQ: if (!tx_busy) begin
        txv_n   = 1'b1;
        state_n = TX_HOLD;
      end
      TX_HOLD: if (tx_busy) begin
        txv_n   = 1'b0;
        state_n = IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      tx_p_data  <= '0;
      tx_d_valid <= 1'b0;
      rf_addr    <= '0;
      rf_wr_en   <= 1'b0;
      rf_wr_data <= '0;
      rf_rd_en   <= 1'b0;
      cmd_err    <= 1'b0;
      ctrl_busy  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      tx_p_data  <= txd_n;
      tx_d_valid <= txv_n;
      rf_addr    <= addr_n;
      rf_wr_en   <= wr_n;
      rf_wr_data <= wdata_n;
      rf_rd_en   <= rd_n;
      cmd_err    <= err_n;
      ctrl_busy  <= (state_n != IDLE);
    end
  end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: frame-level model checked every cycle, RF and TX
// responders, and directed scenarios with literal expectations.
module tb_uart_cmd_ctrl;
  localparam int RD_TO = 16;

  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] rx_p_data = '0, rf_rd_data = '0, tx_p_data, rf_wr_data;
  logic       rx_d_valid = 1'b0, rx_err = 1'b0, tx_busy = 1'b0, rf_rd_valid = 1'b0;
  logic       tx_d_valid, rf_wr_en, rf_rd_en, cmd_err, ctrl_busy;
  logic [3:0] rf_addr;

  uart_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RD_TIMEOUT(RD_TO)) dut (
    .clk(clk), .rst(rst), .rx_p_data(rx_p_data), .rx_d_valid(rx_d_valid), .rx_err(rx_err),
    .tx_busy(tx_busy), .tx_p_data(tx_p_data), .tx_d_valid(tx_d_valid), .rf_addr(rf_addr),
    .rf_wr_en(rf_wr_en), .rf_wr_data(rf_wr_data), .rf_rd_en(rf_rd_en), .rf_rd_data(rf_rd_data),
    .rf_rd_valid(rf_rd_valid), .cmd_err(cmd_err), .ctrl_busy(ctrl_busy)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a byte queue for the open frame plus a response phase
  // (0 none, 1 awaiting read data, 2 transmitting).
  logic [7:0] frame[$];
  int         phase = 0, waited = 0, cyc = 0;
  bit         hold = 0, model_on = 0;
  logic       exp_wr = 0, exp_rd = 0, exp_err = 0, exp_txv = 0, exp_busy = 0, exp_rst = 0;
  logic [3:0] exp_addr = '0;
  logic [7:0] exp_wdata = '0, exp_txd = '0, b1;

  always @(posedge clk) begin
    int p0;
    cyc++;
    model_on = 1;
    exp_wr = 0; exp_rd = 0; exp_err = 0;
    if (rst) begin
      frame.delete();
      phase = 0; hold = 0;
      exp_txv = 0; exp_txd = '0; exp_busy = 0; exp_rst = 1;
    end else begin
      exp_rst = 0;
      p0 = phase;
      if (phase == 1) begin
        if (rf_rd_valid) begin
          exp_txd = rf_rd_data; phase = 2; hold = 0;
        end else begin
          waited++;
          if (waited == RD_TO) begin exp_err = 1; phase = 0; end
        end
      end else if (phase == 2) begin
        if (!hold && !tx_busy) begin exp_txv = 1; hold = 1; end
        else if (hold && tx_busy) begin exp_txv = 0; phase = 0; end
      end
      if (rx_d_valid) begin
        if (p0 != 0 || rx_err) begin
          exp_err = 1;
          frame.delete();
        end else begin
          frame.push_back(rx_p_data);
          if (frame.size() > 1) b1 = frame[1];
          case (frame[0])
            8'hAA: if (frame.size() == 3) begin
              exp_wr = 1; exp_addr = b1[3:0]; exp_wdata = frame[2]; frame.delete();
            end
            8'hBB: if (frame.size() == 2) begin
              exp_rd = 1; exp_addr = b1[3:0]; phase = 1; waited = 0; frame.delete();
            end
            8'hCC: begin exp_txd = 8'h5A; phase = 2; hold = 0; frame.delete(); end
            default: begin exp_err = 1; frame.delete(); end
          endcase
        end
      end
      exp_busy = (phase != 0) || (frame.size() != 0);
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("tx_d_valid", tx_d_valid, exp_txv);
      check("rf_wr_en", rf_wr_en, exp_wr);
      check("rf_rd_en", rf_rd_en, exp_rd);
      check("cmd_err", cmd_err, exp_err);
      check("ctrl_busy", ctrl_busy, exp_busy);
      if (exp_wr) begin
        check("wr_addr", rf_addr, exp_addr);
        check("wr_data", rf_wr_data, exp_wdata);
      end
      if (exp_rd) check("rd_addr", rf_addr, exp_addr);
      if (phase == 2) check("tx_p_data", tx_p_data, exp_txd);
      if (exp_rst) begin
        check("rst_addr", rf_addr, 0);
        check("rst_wdata", rf_wr_data, 0);
        check("rst_txd", tx_p_data, 0);
      end
    end
  end

  // Event log used by the literal expectations.
  int         wr_cnt = 0, rd_cnt = 0, err_cnt = 0, tx_cnt = 0, rd_cyc = 0, err_cyc = 0;
  logic [3:0] last_wr_addr = '0, last_rd_addr = '0;
  logic [7:0] last_wr_data = '0, last_tx = '0;
  logic       txv_q = 0;
  always @(negedge clk) begin
    if (rf_wr_en === 1'b1) begin wr_cnt++; last_wr_addr = rf_addr; last_wr_data = rf_wr_data; end
    if (rf_rd_en === 1'b1) begin rd_cnt++; last_rd_addr = rf_addr; rd_cyc = cyc; end
    if (cmd_err === 1'b1) begin err_cnt++; err_cyc = cyc; end
    if (tx_d_valid === 1'b1 && !txv_q) begin tx_cnt++; last_tx = tx_p_data; end
    txv_q = (tx_d_valid === 1'b1);
  end

  // RF responder: rd_lat cycles after rf_rd_en (0 = never answers).
  int         rd_lat = 2, rd_left = 0;
  logic [7:0] rd_resp = 8'h81;
  always @(negedge clk) begin
    rf_rd_valid = 1'b0;
    if (rf_rd_en === 1'b1 && rd_lat > 0) rd_left = rd_lat;
    else if (rd_left > 0) begin
      rd_left--;
      if (rd_left == 0) begin rf_rd_valid = 1'b1; rf_rd_data = rd_resp; end
    end
  end

  // UART TX model: forced busy via tx_hold, otherwise busy for a few cycles per request.
  bit tx_hold = 0;
  int busy_left = 0;
  always @(negedge clk) begin
    if (tx_hold) tx_busy = 1'b1;
    else if (tx_busy) begin
      if (busy_left == 0) tx_busy = 1'b0;
      else busy_left--;
    end else if (tx_d_valid === 1'b1) begin
      tx_busy = 1'b1; busy_left = 3;
    end
  end

  task automatic send(input logic [7:0] b, input logic e = 1'b0);
    @(negedge clk);
    rx_p_data = b; rx_d_valid = 1'b1; rx_err = e;
    @(negedge clk);
    rx_d_valid = 1'b0; rx_err = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int tx_before;
    repeat (3) @(negedge clk);
    check("reset_busy", ctrl_busy, 0);
    check("reset_txv", tx_d_valid, 0);
    check("reset_err", cmd_err, 0);
    rst = 1'b0;

    send(8'hAA); send(8'h03); send(8'h5C); idle(3);
    check("w_cnt", wr_cnt, 1);
    check("w_addr", last_wr_addr, 4'h3);
    check("w_data", last_wr_data, 8'h5C);
    check("w_noerr", err_cnt, 0);

    rd_lat = 2; rd_resp = 8'h81;
    send(8'hBB); send(8'h07); idle(12);
    check("r_cnt", rd_cnt, 1);
    check("r_addr", last_rd_addr, 4'h7);
    check("r_tx_cnt", tx_cnt, 1);
    check("r_tx_byte", last_tx, 8'h81);
    check("r_noerr", err_cnt, 0);

    tx_hold = 1;
    tx_before = tx_cnt;
    send(8'hCC); idle(20);
    check("ping_held", tx_cnt, tx_before);
    tx_hold = 0;
    idle(10);
    check("ping_sent", tx_cnt, tx_before + 1);
    check("ping_byte", last_tx, 8'h5A);

    send(8'h12); idle(2);
    check("bad_op_err", err_cnt, 1);
    send(8'hAA); send(8'h02); send(8'h55, 1'b1); idle(3);
    check("rxerr_err", err_cnt, 2);
    check("rxerr_nowr", wr_cnt, 1);

    rd_lat = 0;
    send(8'hBB); send(8'h01); idle(25);
    check("to_err", err_cnt, 3);
    check("to_dist", err_cyc - rd_cyc, RD_TO);
    send(8'hAA); send(8'h01); send(8'h33); idle(3);
    check("to_next_wr", wr_cnt, 2);
    check("to_next_addr", last_wr_addr, 4'h1);
    check("to_next_data", last_wr_data, 8'h33);

    rd_lat = 4; rd_resp = 8'hC3;
    send(8'hBB); send(8'h05); send(8'h09); idle(14);
    check("drop_err", err_cnt, 4);
    check("drop_tx", last_tx, 8'hC3);

    send(8'hAA); send(8'h04);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_addr", rf_addr, 0);
    check("mid_rst_busy", ctrl_busy, 0);
    check("mid_rst_txd", tx_p_data, 0);
    send(8'h77); idle(3);
    check("mid_rst_err", err_cnt, 5);
    check("mid_rst_nowr", wr_cnt, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Byte-level command controller between the UART receiver/transmitter and the register file. Parses command frames from the UART RX byte stream, performs register-file writes and reads, and returns read data through the UART TX parallel interface using its busy handshake. All inputs are already synchronized into `clk`; the block runs on one clock.

## Interface

**Parameters**
- `DATA_WIDTH`, 8: UART byte and register width.
- `ADDR_WIDTH`, 4: register-file address width. The low `ADDR_WIDTH` bits of the address byte are used; upper bits are ignored.
- `RD_TIMEOUT`, 16: maximum cycles to wait for `rf_rd_valid`, counted from the `rf_rd_en` cycle.

**Ports**
- `clk`, input, 1: single clock.
- `rst`, input, 1: synchronous, active-high reset.
- `rx_p_data`, input, `DATA_WIDTH`: received byte.
- `rx_d_valid`, input, 1: one-cycle pulse per received byte.
- `rx_err`, input, 1: parity or stop error for the byte; qualified by `rx_d_valid`.
- `tx_busy`, input, 1: UART TX busy.
- `tx_p_data`, output, `DATA_WIDTH`: byte to transmit.
- `tx_d_valid`, output, 1: transmit request.
- `rf_addr`, output, `ADDR_WIDTH`: register address.
- `rf_wr_en`, output, 1: one-cycle write strobe.
- `rf_wr_data`, output, `DATA_WIDTH`: write data.
- `rf_rd_en`, output, 1: one-cycle read strobe.
- `rf_rd_data`, input, `DATA_WIDTH`: read data.
- `rf_rd_valid`, input, 1: read data valid pulse.
- `cmd_err`, output, 1: one-cycle error pulse.
- `ctrl_busy`, output, 1: high when the state is not IDLE.

## Operation

**Commands** (first byte of each frame)
- 0xAA: write. The next byte is the address; the byte after that is the data.
- 0xBB: read. The next byte is the address.
- 0xCC: ping. Transmits 0x5A.
- Any other first byte: pulse `cmd_err`, stay in IDLE.

**States and transitions**
- IDLE:
  - 0xAA goes to WR_ADDR.
  - 0xBB goes to RD_ADDR.
  - 0xCC loads 0x5A into the TX buffer and goes to TX_REQ.
- WR_ADDR: on a byte, latch the address and go to WR_DATA.
- WR_DATA: on a byte, register `rf_addr` and `rf_wr_data`, pulse `rf_wr_en`, go to IDLE.
- RD_ADDR: on a byte, latch the address, pulse `rf_rd_en`, clear the timeout counter, go to RD_WAIT.
- RD_WAIT:
  - On `rf_rd_valid`, latch `rf_rd_data` into the TX buffer and go to TX_REQ.
  - If the counter reaches `RD_TIMEOUT` first, pulse `cmd_err` and go to IDLE.
- TX_REQ: wait for `tx_busy` = 0, then assert `tx_d_valid` and go to TX_HOLD.
- TX_HOLD: keep `tx_d_valid` high until `tx_busy` = 1 is sampled, deassert it on the next cycle, go to IDLE.

**Boundary rules**
- `rx_d_valid` with `rx_err` = 1 in any parsing state (IDLE, WR_ADDR, WR_DATA, RD_ADDR):
  - Discard the byte.
  - Abort the frame with no RF strobe.
  - Pulse `cmd_err`, go to IDLE.
- `rx_d_valid` in RD_WAIT, TX_REQ or TX_HOLD: drop the byte, pulse `cmd_err`, keep the current state.
- `rf_rd_valid` outside RD_WAIT is ignored.
- If `rf_rd_valid` and the timeout occur in the same cycle, the data wins.
- `tx_p_data` is stable from TX_REQ entry until IDLE.
- The timeout counter is `clog2(RD_TIMEOUT)+1` bits, saturating, and is reset on RD_WAIT entry.
- `rst` asserted mid-frame forces IDLE on the next edge and discards any partial frame and pending TX.

## Timing

- Reset values: state IDLE; `tx_p_data` = 0, `tx_d_valid` = 0, `rf_addr` = 0, `rf_wr_en` = 0, `rf_wr_data` = 0, `rf_rd_en` = 0, `cmd_err` = 0, `ctrl_busy` = 0.
- All outputs are registered.
- Command byte at cycle N: the new state and `ctrl_busy` are visible at N+1.
- Write: data byte at cycle M gives `rf_wr_en` = 1 with valid `rf_addr`/`rf_wr_data` at M+1, for exactly 1 cycle; IDLE at M+1.
- Read: address byte at M gives `rf_rd_en` = 1 at M+1, for 1 cycle.
  - `rf_rd_valid` at K gives TX_REQ at K+1; `tx_d_valid` rises at K+2 at the earliest.
  - Timeout: `cmd_err` is pulsed at cycle M+1+`RD_TIMEOUT` when no `rf_rd_valid` has arrived.
- Handshake: `tx_d_valid` is never asserted while `tx_busy` was 1 in the previous cycle. Once asserted, it is held until `tx_busy` = 1, then dropped the cycle after.
- `cmd_err` is pulsed for 1 cycle per event, one cycle after the triggering input.

## Test plan

- Write: bytes 0xAA, 0x03, 0x5C → exactly one `rf_wr_en` pulse with `rf_addr` = 3 and `rf_wr_data` = 0x5C, one cycle after the third byte; `cmd_err` = 0.
- Read: bytes 0xBB, 0x07; RF model returns 0x81 two cycles after `rf_rd_en` → `rf_rd_en` pulsed once with addr 7; `tx_p_data` = 0x81; `tx_d_valid` held until `tx_busy` rises, dropped the next cycle.
- TX contention: `tx_busy` held at 1 for 20 cycles while a ping (0xCC) is pending → `tx_d_valid` stays 0 until `tx_busy` = 0, then transmits 0x5A.
- Errors:
  - Byte 0x12 in IDLE → `cmd_err` pulse, no RF strobe.
  - 0xAA, 0x02, then a byte with `rx_err` = 1 → `cmd_err`, no `rf_wr_en`, IDLE.
- Timeout: 0xBB, 0x01, with `rf_rd_valid` never asserted → `cmd_err` exactly 16 cycles after `rf_rd_en`; next frame 0xAA, 0x01, 0x33 is processed normally.
- Reset mid-frame: 0xAA, 0x04, then `rst` for 1 cycle, then 0x77 → all outputs are 0 after reset; 0x77 is treated as an unknown opcode (`cmd_err`), no write.
